// File: rtl/md_pkg.sv
// md_pkg: shared types, constants and arithmetic helpers for the multiply/divide unit.
package md_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL  = 3'd1,
        ST_DIV  = 3'd2,
        ST_WLO  = 3'd3,
        ST_WHI  = 3'd4
    } md_state_t;

    localparam logic [5:0] REG_LO   = 6'd32;
    localparam logic [5:0] REG_HI   = 6'd33;
    localparam int         MUL_LAT  = 2;
    localparam int         DIV_ITER = 32;

    // Low 64 bits of the product; extending both operands to 64 bits makes one
    // unsigned multiplier serve both the signed and unsigned forms.
    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b,
                                          input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // Magnitude of a word; 32'h80000000 maps to itself, which is its correct unsigned magnitude.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic sgn);
        return (sgn && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/md_div_core.sv
// md_div_core: iterative radix-2 restoring divider on unsigned magnitudes.
// start loads the operands, each step cycle retires one quotient bit, and
// quo_next/rem_next expose the value the registers take on that step.
module md_div_core
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        start,
    input  logic        step,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] quo_next,
    output logic [31:0] rem_next,
    output logic        done
);

    logic [31:0] rem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic [4:0]  cnt_q;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted  = {rem_q, quo_q[31]};
        diff     = shifted - {1'b0, dvs_q};
        ge       = (shifted >= {1'b0, dvs_q});
        rem_next = ge ? diff[31:0] : shifted[31:0];
        quo_next = {quo_q[30:0], ge};
    end

    assign done = step && (cnt_q == 5'd0);

    // Operand load on start, otherwise iterate while the controller steps us.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else if (start) begin
            rem_q <= '0;
            quo_q <= dividend;
            dvs_q <= divisor;
            cnt_q <= 5'(DIV_ITER - 1);
        end else if (step) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (cnt_q != 5'd0) cnt_q <= cnt_q - 5'd1;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// md_ctrl: multiply/divide controller. Owns the operation FSM, the signed
// fix-up of divider results and the two-beat LO/HI write-port handshake.
// Optional: define MD_DIV_EARLY_OUT_EN to finish a divide in one cycle when
// |dividend| < |divisor|.
//
// state | meaning
// IDLE  | waiting for mult_en/div_en
// MUL   | product settling, MUL_LAT cycles
// DIV   | divider iterating, one quotient bit per cycle
// WLO   | requesting write of LO (reg 32) until granted
// WHI   | requesting write of HI (reg 33) until granted
module md_ctrl
    import md_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        mult_en,
    input  logic        div_en,
    input  logic        is_signed,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        md_busy,
    output logic        md_stall,
    output logic        md_wreq,
    input  logic        md_wgnt,
    output logic [5:0]  md_waddr,
    output logic [31:0] md_wdata
);

    md_state_t   state;
    logic        sgn_q;
    logic [31:0] a_q;
    logic [31:0] b_q;
    logic [31:0] hi_q;
    logic [1:0]  mcnt_q;

    logic        div_start;
    logic        div_step;
    logic        div_done;
    logic [31:0] quo_next;
    logic [31:0] rem_next;
    logic [63:0] product;
    logic        early_hit;
    logic        div_fin;
    logic [31:0] div_lo;
    logic [31:0] div_hi;

    assign md_busy   = (state != ST_IDLE);
    assign md_stall  = md_busy && (mult_en || div_en);
    assign div_start = (state == ST_IDLE) && div_en && !mult_en;
    assign div_step  = (state == ST_DIV);
    assign product   = mul64(a_q, b_q, sgn_q);

    md_div_core u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start    (div_start),
        .step     (div_step),
        .dividend (mag32(src1, is_signed)),
        .divisor  (mag32(src2, is_signed)),
        .quo_next (quo_next),
        .rem_next (rem_next),
        .done     (div_done)
    );

`ifdef MD_DIV_EARLY_OUT_EN
    logic div_first_q;
    assign early_hit = div_first_q && (b_q != 32'd0) &&
                       (mag32(a_q, sgn_q) < mag32(b_q, sgn_q));
`else
    assign early_hit = 1'b0;
`endif

    // Final divide result: divide-by-zero and early-out bypass the sign fix-up.
    always_comb begin
        div_fin = div_done || early_hit;
        if (early_hit) begin
            div_lo = 32'd0;
            div_hi = a_q;
        end else if (b_q == 32'd0) begin
            div_lo = 32'hFFFF_FFFF;
            div_hi = a_q;
        end else begin
            div_lo = (sgn_q && (a_q[31] ^ b_q[31])) ? (~quo_next + 32'd1) : quo_next;
            div_hi = (sgn_q && a_q[31]) ? (~rem_next + 32'd1) : rem_next;
        end
    end

    // Operation FSM with registered write-port outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            sgn_q    <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            hi_q     <= '0;
            mcnt_q   <= '0;
            md_wreq  <= 1'b0;
            md_waddr <= '0;
            md_wdata <= '0;
`ifdef MD_DIV_EARLY_OUT_EN
            div_first_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mult_en || div_en) begin
                        a_q   <= src1;
                        b_q   <= src2;
                        sgn_q <= is_signed;
                        if (mult_en) begin
                            state  <= ST_MUL;
                            mcnt_q <= 2'(MUL_LAT - 1);
                        end else begin
                            state <= ST_DIV;
`ifdef MD_DIV_EARLY_OUT_EN
                            div_first_q <= 1'b1;
`endif
                        end
                    end
                end
                ST_MUL: begin
                    if (mcnt_q == 2'd0) begin
                        hi_q     <= product[63:32];
                        md_wreq  <= 1'b1;
                        md_waddr <= REG_LO;
                        md_wdata <= product[31:0];
                        state    <= ST_WLO;
                    end else begin
                        mcnt_q <= mcnt_q - 2'd1;
                    end
                end
                ST_DIV: begin
`ifdef MD_DIV_EARLY_OUT_EN
                    div_first_q <= 1'b0;
`endif
                    if (div_fin) begin
                        hi_q     <= div_hi;
                        md_wreq  <= 1'b1;
                        md_waddr <= REG_LO;
                        md_wdata <= div_lo;
                        state    <= ST_WLO;
                    end
                end
                ST_WLO: begin
                    if (md_wgnt) begin
                        md_waddr <= REG_HI;
                        md_wdata <= hi_q;
                        state    <= ST_WHI;
                    end
                end
                ST_WHI: begin
                    if (md_wgnt) begin
                        md_wreq <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    md_wreq <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_md_ctrl.sv
// tb_md_ctrl: directed plus randomized bench for md_ctrl against an arithmetic reference model.
module tb_md_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mult_en;
    logic        div_en;
    logic        is_signed;
    logic [31:0] src1;
    logic [31:0] src2;
    logic        md_busy;
    logic        md_stall;
    logic        md_wreq;
    logic        md_wgnt;
    logic [5:0]  md_waddr;
    logic [31:0] md_wdata;

    int checks = 0;
    int errors = 0;

    md_ctrl dut (
        .clk       (clk),
        .resetn    (resetn),
        .mult_en   (mult_en),
        .div_en    (div_en),
        .is_signed (is_signed),
        .src1      (src1),
        .src2      (src2),
        .md_busy   (md_busy),
        .md_stall  (md_stall),
        .md_wreq   (md_wreq),
        .md_wgnt   (md_wgnt),
        .md_waddr  (md_waddr),
        .md_wdata  (md_wdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: results from plain 64-bit integer arithmetic, latency from the op kind.
    task automatic model(input bit is_mul, input bit sgn, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] lo,
                         output logic [31:0] hi, output int lat);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = sgn ? longint'($signed(a)) : longint'({32'h0, a});
        sb = sgn ? longint'($signed(b)) : longint'({32'h0, b});
        if (is_mul) begin
            p   = 64'(sa * sb);
            lo  = p[31:0];
            hi  = p[63:32];
            lat = 3;
        end else begin
            lat = 33;
            if (b == 32'd0) begin
                lo = 32'hFFFF_FFFF;
                hi = a;
            end else begin
                q  = sa / sb;
                r  = sa % sb;
                lo = 32'(q);
                hi = 32'(r);
`ifdef MD_DIV_EARLY_OUT_EN
                if ((sa < 0 ? -sa : sa) < (sb < 0 ? -sb : sb)) lat = 2;
`endif
            end
        end
    endtask

    task automatic run_op(input bit m, input bit d, input bit sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
        logic [31:0] exp_lo, exp_hi;
        int exp_lat, k;
        model(m, sgn, a, b, exp_lo, exp_hi, exp_lat);
        @(negedge clk);
        mult_en = m; div_en = d; is_signed = sgn; src1 = a; src2 = b; md_wgnt = 1'b0;
        @(negedge clk);
        mult_en = 1'b0; div_en = 1'b0; src1 = $urandom; src2 = $urandom;
        k = 1;
        while (md_wreq !== 1'b1 && k < 60) begin
            check("busy_while_computing", md_busy, 1'b1);
            @(negedge clk);
            k++;
        end
        check("wreq_latency", 32'(k), 32'(exp_lat));
        for (int h = 0; h <= hold; h++) begin
            check("wlo_wreq", md_wreq, 1'b1);
            check("wlo_waddr", md_waddr, 6'd32);
            check("wlo_wdata", md_wdata, exp_lo);
            if (h == 1) begin
                div_en = 1'b1;
                #1 check("stall_in_wlo", md_stall, 1'b1);
            end
            md_wgnt = (h == hold);
            @(negedge clk);
            div_en = 1'b0;
        end
        check("whi_wreq", md_wreq, 1'b1);
        check("whi_waddr", md_waddr, 6'd33);
        check("whi_wdata", md_wdata, exp_hi);
        md_wgnt = 1'b1;
        @(negedge clk);
        md_wgnt = 1'b0;
        check("idle_busy", md_busy, 1'b0);
        check("idle_wreq", md_wreq, 1'b0);
    endtask

    initial begin
        int seen;
        logic [31:0] a, b;
        int sel, r;
        resetn = 1'b0; mult_en = 1'b0; div_en = 1'b0; is_signed = 1'b0;
        src1 = '0; src2 = '0; md_wgnt = 1'b0;
        repeat (3) @(negedge clk);
        mult_en = 1'b1;
        #1;
        check("reset_busy", md_busy, 1'b0);
        check("reset_wreq", md_wreq, 1'b0);
        check("reset_stall", md_stall, 1'b0);
        mult_en = 1'b0;
        resetn = 1'b1;

        // Directed cases from the requirements.
        run_op(1, 0, 1, 32'hFFFF_FFFD, 32'd5, 0);
        run_op(0, 1, 0, 32'd100, 32'd7, 0);
        run_op(0, 1, 1, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(0, 1, 0, 32'd5, 32'd0, 0);
        run_op(0, 1, 0, 32'd3, 32'd10, 0);
        run_op(0, 1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 3);
        run_op(0, 1, 1, 32'hFFFF_FFF0, 32'd0, 1);
        run_op(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2);
        run_op(1, 0, 1, 32'h8000_0000, 32'h8000_0000, 3);

        // Reset in the middle of a divide.
        @(negedge clk);
        div_en = 1'b1; is_signed = 1'b0; src1 = 32'd1000; src2 = 32'd3;
        @(negedge clk);
        div_en = 1'b0;
        repeat (9) @(negedge clk);
        resetn = 1'b0;
        @(negedge clk);
        check("abort_busy", md_busy, 1'b0);
        check("abort_wreq", md_wreq, 1'b0);
        resetn = 1'b1;
        md_wgnt = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (md_wreq === 1'b1 || md_busy === 1'b1) seen++;
        end
        check("abort_no_write", 32'(seen), 32'd0);
        md_wgnt = 1'b0;

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            sel = $urandom_range(0, 2);
            a = $urandom;
            r = $urandom_range(0, 3);
            case (r)
                0: b = 32'($urandom_range(0, 15));
                1: b = $urandom;
                2: b = 32'(-$urandom_range(1, 100));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(16, 31);
            run_op(sel != 1, sel != 0, 1'($urandom_range(0, 1)), a, b, $urandom_range(0, 3));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 clk  in  1  pipeline clock; all state changes on posedge clk.
REQ-002 resetn  in  1  reset, synchronous, active-low.
REQ-003 mult_en  in  1  decode: MULT/MULTU issued this cycle.
REQ-004 div_en  in  1  decode: DIV/DIVU issued this cycle.
REQ-005 is_signed  in  1  signed operation (MULT/DIV).
REQ-006 src1  in  32  forwarded rs value (multiplicand / dividend).
REQ-007 src2  in  32  forwarded rt value (multiplier / divisor).
REQ-008 md_busy  out  1  unit not IDLE; hazard unit stalls MFHI/MFLO/MTHI/MTLO.
REQ-009 md_stall  out  1  = md_busy & (mult_en | div_en); new MD op must hold in decode.
REQ-010 md_wreq  out  1  request for the shared regfile write port.
REQ-011 md_wgnt  in  1  write port granted this cycle (WB has priority; arbiter external).
REQ-012 md_waddr  out  6  6'd32 (LO) or 6'd33 (HI).
REQ-013 md_wdata  out  32  result word for md_waddr.

Function
REQ-014 FSM states IDLE, MUL, DIV, WLO, WHI; md_busy = (state != IDLE).
REQ-015 Accept: in IDLE with mult_en|div_en sampled high (cycle N) -> latch src1, src2, is_signed, op; mult_en wins if both high.
REQ-016 Requests while not IDLE are ignored (not queued); md_stall asserted instead.
REQ-017 MUL: 64-bit product, signed/unsigned per is_signed; occupies cycles N+1, N+2; WLO from N+3.
REQ-018 DIV: radix-2 restoring on operand magnitudes, one quotient bit per cycle, cycles N+1..N+32; WLO from N+33.
REQ-019 Signed DIV: quotient negated iff operand signs differ; remainder takes dividend sign; 32'h80000000/-1 gives LO=32'h80000000, HI=0.
REQ-020 Divisor zero: LO=32'hFFFFFFFF, HI=src1, same latency as a normal divide.
REQ-021 WLO: md_wreq=1, md_waddr=6'd32, md_wdata=LO; held stable until md_wgnt; on grant -> WHI.
REQ-022 WHI: md_wreq=1, md_waddr=6'd33, md_wdata=HI; on grant -> IDLE; no accept in the WHI-grant cycle.
REQ-023 md_wreq low in IDLE, MUL, DIV; md_waddr/md_wdata are don't-care when md_wreq low.

Reset
REQ-024 resetn low at posedge -> state IDLE, md_wreq 0, md_busy 0, iteration counter 0, operand/result regs 0.
REQ-025 Reset mid-operation (any state) aborts it; no HI/LO write ever issues for the aborted op.

Configuration
REQ-026 Macro MD_DIV_EARLY_OUT_EN defined: in first DIV cycle, if |dividend| < |divisor| and divisor != 0, result LO=0, HI=dividend (signed: original src1), DIV lasts 1 cycle, WLO from N+2.
REQ-027 Macro undefined: every divide takes the full 32 DIV cycles of REQ-018.

Structure
REQ-028 Package md_pkg: state encoding, REG_LO=6'd32, REG_HI=6'd33, MUL_LAT=2, DIV_ITER=32.
REQ-029 Sub-module md_div_core: iterative divider datapath (shift/subtract regs, 5-bit counter, done pulse); md_ctrl owns FSM, sign fix-up, write sequencing.

Verification
REQ-030 MULT -3 x 5, gnt tied high -> wreq at N+3: LO=32'hFFFFFFF1; N+4: HI=32'hFFFFFFFF; busy low at N+5.
REQ-031 DIVU 100/7 -> wreq at N+33: LO=32'h0000000E, then HI=32'h00000002.
REQ-032 DIV -7/2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; DIVU 5/0 -> LO=32'hFFFFFFFF, HI=5.
REQ-033 md_wgnt low 3 cycles in WLO -> wreq/waddr/wdata stable; div_en pulse meanwhile -> md_stall=1, op not accepted.
REQ-034 resetn low at N+10 of a DIV -> next cycle IDLE, md_busy 0, no wreq observed afterwards.
REQ-035 DIVU 3/10 -> with MD_DIV_EARLY_OUT_EN wreq at N+2 (LO=0, HI=3); without, at N+33 with the same values.
